buffered_coupler: RTL and testbench
===================================

BUFFERED_COUPLER -- requirements
Module: buffered_coupler

Interface
REQ-001 SHALL have parameter NUM_ELEMENTS, default 4: number of input lanes (>=1).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: bits per lane element.
REQ-003 SHALL have parameter MASK_DEPTH, default 8: mask FIFO entries (power of two, >=2).
REQ-004 SHALL have parameter LANE_DEPTH, default 4: per-lane FIFO entries (power of two, >=2).
REQ-005 SHALL have parameter CONSUME_UNKEPT, default 0: 1 = lanes with mask keep=0 are also popped and discarded.
REQ-006 SHALL have ports in this order:
  - clk  in  1  sole clock; all state on rising edge.
  - rst_n  in  1  reset, asynchronous, active-low.
  - mask_data  in  NUM_ELEMENTS+1  [NUM_ELEMENTS:1] lane keep, [0] last.
  - mask_valid / mask_ready  in / out  1  mask handshake.
  - in_data  in  NUM_ELEMENTS*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH].
  - in_keep  in  NUM_ELEMENTS  per-lane element keep.
  - in_valid / in_ready  in / out  NUM_ELEMENTS  per-lane handshake.
  - out_data  out  NUM_ELEMENTS*DATA_WIDTH  coupled beat.
  - out_keep  out  NUM_ELEMENTS  coupled keep.
  - out_last  out  1  packet end.
  - out_valid / out_ready  out / in  1  output handshake.
  - beat_count  out  32  output beats transferred.
  - packet_count  out  32  output beats transferred with out_last=1.

Function
REQ-007 Handshake rule everywhere: transfer iff valid && ready on a rising edge; valid, once high, SHALL NOT be dropped by this block until transfer.
REQ-008 Mask FIFO: MASK_DEPTH entries; mask_ready = !mask_full; no write-through; a pop and a push in the same cycle SHALL both take effect.
REQ-009 Lane FIFO i: LANE_DEPTH entries of {in_data lane i, in_keep[i]}; in_ready[i] = !lane_full[i]; same push/pop rules as REQ-008.
REQ-010 required[i] = mask_keep[i] || CONSUME_UNKEPT, evaluated on the mask FIFO head.
REQ-011 join = mask FIFO non-empty && lane FIFO i non-empty for every i with required[i]=1.
REQ-012 load = join && (!out_valid || out_ready); on load, pop mask FIFO and every required lane FIFO in the same edge; non-required lanes SHALL NOT be popped.
REQ-013 Output register on load: out_data lane i = lane head data if mask_keep[i] else 0; out_keep[i] = mask_keep[i] && head keep[i] (0 if not required); out_last = mask_last; out_valid <= 1.
REQ-014 out_valid SHALL clear on out_ready && !load; hold stable (all out_* unchanged) while out_valid && !out_ready.
REQ-015 Latency: mask and all required lane data accepted on edge k into empty FIFOs -> out_valid=1 after edge k+1; sustained throughput 1 beat/cycle.
REQ-016 Mask with all keep=0: with CONSUME_UNKEPT=0, joins with no lane data present (empty beat, out_keep=0) and still forwards last.
REQ-017 Lanes with data but no matching mask SHALL be held (backpressured via full) and never dropped.
REQ-018 beat_count +1 per output transfer; packet_count +1 per output transfer with out_last=1; both wrap 2^32-1 -> 0.

Reset
REQ-019 While rst_n=0: FIFOs empty, out_valid=0, out_data=0, out_keep=0, out_last=0, counters=0, mask_ready=0, in_ready=0.
REQ-020 Reset assertion mid-operation SHALL discard all buffered mask and lane entries immediately; first edge after rst_n=1 sees mask_ready=1, in_ready all 1.

Verification
REQ-021 N=4: mask {keep=4'b1111,last=1}, lanes carry 0xA0..0xA3 same cycle k -> out_valid after k+1, out_data={A3,A2,A1,A0}, out_last=1, packet_count=1.
REQ-022 mask keep=4'b0101, CONSUME_UNKEPT=0, lanes 1 and 3 each hold one beat -> out lanes 1,3 = 0, out_keep=4'b0101, lane 1/3 FIFOs still hold their beat.
REQ-023 Same as REQ-022 with CONSUME_UNKEPT=1 and lane 3 empty -> no output until lane 3 written; then all four lanes popped, out_keep=4'b0101.
REQ-024 out_ready=0 for 20 cycles, masks and full lanes streaming -> mask_ready=0 after MASK_DEPTH+1 masks, in_ready=0 after LANE_DEPTH+1 beats, held output stable, no loss on release.
REQ-025 Continuous stream, out_ready=1 -> one beat per cycle; beat_count preset near 2^32-1 wraps to 0.
REQ-026 rst_n pulsed low with 3 beats buffered -> out_valid=0 asynchronously, counters 0, no stale beat emitted after release.

Source files
------------

// File: rtl/buffered_coupler.sv
// Joins a stream of lane-select masks with NUM_ELEMENTS independent lane streams.
// Each beat holds the lane data picked by its mask and carries the mask's last flag.
module buffered_coupler #(
    parameter int NUM_ELEMENTS   = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int MASK_DEPTH     = 8,
    parameter int LANE_DEPTH     = 4,
    parameter int CONSUME_UNKEPT = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_ELEMENTS:0]              mask_data,
    input  logic                               mask_valid,
    output logic                               mask_ready,
    input  logic [NUM_ELEMENTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_ELEMENTS-1:0]            in_keep,
    input  logic [NUM_ELEMENTS-1:0]            in_valid,
    output logic [NUM_ELEMENTS-1:0]            in_ready,
    output logic [NUM_ELEMENTS*DATA_WIDTH-1:0] out_data,
    output logic [NUM_ELEMENTS-1:0]            out_keep,
    output logic                               out_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [31:0]                        beat_count,
    output logic [31:0]                        packet_count
);
    localparam int MAW = $clog2(MASK_DEPTH);
    localparam int LAW = $clog2(LANE_DEPTH);
    localparam int LW  = NUM_ELEMENTS * DATA_WIDTH;
    localparam logic [MAW:0] MASK_PTR_ONE = 1;
    localparam logic [LAW:0] LANE_PTR_ONE = 1;

    // Mask FIFO: head is read combinationally so a join can fire the edge after the write.
    logic [NUM_ELEMENTS:0] mask_mem_q [MASK_DEPTH];
    logic [MAW:0]          mask_wr_q;
    logic [MAW:0]          mask_rd_q;
    logic                  mask_full;
    logic                  mask_empty;
    logic                  mask_push;
    logic [NUM_ELEMENTS:0] mask_head;
    logic [NUM_ELEMENTS-1:0] mask_keep;
    logic                  mask_last;

    logic [NUM_ELEMENTS-1:0] lane_nonempty;
    logic [NUM_ELEMENTS-1:0] lane_head_keep;
    logic [LW-1:0]           lane_head_data;
    logic [NUM_ELEMENTS-1:0] lane_pop;
    logic [NUM_ELEMENTS-1:0] required;
    logic                    join_ok;
    logic                    load;
    logic                    out_fire;

    logic [LW-1:0]           out_data_q, out_data_d;
    logic [NUM_ELEMENTS-1:0] out_keep_q, out_keep_d;
    logic                    out_last_q, out_last_d;
    logic                    out_valid_q, out_valid_d;
    logic [31:0]             beat_count_q, beat_count_d;
    logic [31:0]             packet_count_q, packet_count_d;

    assign mask_empty = (mask_wr_q == mask_rd_q);
    assign mask_full  = (mask_wr_q[MAW] != mask_rd_q[MAW]) &&
                        (mask_wr_q[MAW-1:0] == mask_rd_q[MAW-1:0]);
    assign mask_ready = rst_n && !mask_full;
    assign mask_push  = mask_valid && mask_ready;
    assign mask_head  = mask_mem_q[mask_rd_q[MAW-1:0]];
    assign mask_keep  = mask_head[NUM_ELEMENTS:1];
    assign mask_last  = mask_head[0];

    always_ff @(posedge clk) begin
        if (mask_push) begin
            mask_mem_q[mask_wr_q[MAW-1:0]] <= mask_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_wr_q <= '0;
            mask_rd_q <= '0;
        end else begin
            if (mask_push) mask_wr_q <= mask_wr_q + MASK_PTR_ONE;
            if (load)      mask_rd_q <= mask_rd_q + MASK_PTR_ONE;
        end
    end

    for (genvar gi = 0; gi < NUM_ELEMENTS; gi++) begin : g_lane
        logic [DATA_WIDTH:0] mem_q [LANE_DEPTH];
        logic [LAW:0]        wr_q;
        logic [LAW:0]        rd_q;
        logic                full;
        logic                push;
        logic [DATA_WIDTH:0] head;

        assign full  = (wr_q[LAW] != rd_q[LAW]) && (wr_q[LAW-1:0] == rd_q[LAW-1:0]);
        assign in_ready[gi] = rst_n && !full;
        assign push  = in_valid[gi] && in_ready[gi];
        assign head  = mem_q[rd_q[LAW-1:0]];
        assign lane_nonempty[gi] = (wr_q != rd_q);
        assign lane_head_keep[gi] = head[DATA_WIDTH];
        assign lane_head_data[gi*DATA_WIDTH +: DATA_WIDTH] = head[DATA_WIDTH-1:0];

        always_ff @(posedge clk) begin
            if (push) begin
                mem_q[wr_q[LAW-1:0]] <= {in_keep[gi], in_data[gi*DATA_WIDTH +: DATA_WIDTH]};
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push)         wr_q <= wr_q + LANE_PTR_ONE;
                if (lane_pop[gi]) rd_q <= rd_q + LANE_PTR_ONE;
            end
        end
    end

    // Unkept lanes only gate the join (and get popped) when CONSUME_UNKEPT is set.
    assign required = (CONSUME_UNKEPT != 0) ? '1 : mask_keep;
    assign join_ok  = !mask_empty && ((required & ~lane_nonempty) == '0);
    assign load     = join_ok && (!out_valid_q || out_ready);
    assign lane_pop = load ? required : '0;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        out_data_d     = out_data_q;
        out_keep_d     = out_keep_q;
        out_last_d     = out_last_q;
        out_valid_d    = out_valid_q;
        beat_count_d   = beat_count_q + (out_fire ? 32'd1 : 32'd0);
        packet_count_d = packet_count_q + ((out_fire && out_last_q) ? 32'd1 : 32'd0);
        if (load) begin
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
                out_data_d[i*DATA_WIDTH +: DATA_WIDTH] =
                    mask_keep[i] ? lane_head_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                out_keep_d[i] = mask_keep[i] && lane_head_keep[i];
            end
            out_last_d  = mask_last;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q     <= '0;
            out_keep_q     <= '0;
            out_last_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            beat_count_q   <= '0;
            packet_count_q <= '0;
        end else begin
            out_data_q     <= out_data_d;
            out_keep_q     <= out_keep_d;
            out_last_q     <= out_last_d;
            out_valid_q    <= out_valid_d;
            beat_count_q   <= beat_count_d;
            packet_count_q <= packet_count_d;
        end
    end

    assign out_data     = out_data_q;
    assign out_keep     = out_keep_q;
    assign out_last     = out_last_q;
    assign out_valid    = out_valid_q;
    assign beat_count   = beat_count_q;
    assign packet_count = packet_count_q;
endmodule

// File: tb/tb_buffered_coupler.sv
// Scoreboard bench: stimulus queues expected beats, negedge monitors pop and compare.
`timescale 1ns/1ps
module tb_buffered_coupler;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int W  = N * DW;
    localparam int TOT = 12;

    typedef struct {
        logic [W-1:0] data;
        logic [N-1:0] keep;
        logic         last;
    } beat_t;

    logic clk;
    logic rst_n;

    logic [N:0]   mask_data;
    logic         mask_valid, mask_ready;
    logic [W-1:0] in_data;
    logic [N-1:0] in_keep, in_valid, in_ready;
    logic [W-1:0] out_data;
    logic [N-1:0] out_keep;
    logic         out_last, out_valid, out_ready;
    logic [31:0]  beat_count, packet_count;

    logic [N:0]   cu_mask_data;
    logic         cu_mask_valid, cu_mask_ready;
    logic [W-1:0] cu_in_data;
    logic [N-1:0] cu_in_keep, cu_in_valid, cu_in_ready;
    logic [W-1:0] cu_out_data;
    logic [N-1:0] cu_out_keep;
    logic         cu_out_last, cu_out_valid, cu_out_ready;
    logic [31:0]  cu_beat_count, cu_packet_count;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t exp_q[$];
    beat_t cu_exp_q[$];
    beat_t mon_e;
    beat_t cu_mon_e;

    buffered_coupler #(.NUM_ELEMENTS(N), .DATA_WIDTH(DW), .MASK_DEPTH(8),
                       .LANE_DEPTH(4), .CONSUME_UNKEPT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .mask_data(mask_data), .mask_valid(mask_valid), .mask_ready(mask_ready),
        .in_data(in_data), .in_keep(in_keep), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .beat_count(beat_count), .packet_count(packet_count)
    );

    buffered_coupler #(.NUM_ELEMENTS(N), .DATA_WIDTH(DW), .MASK_DEPTH(8),
                       .LANE_DEPTH(4), .CONSUME_UNKEPT(1)) dut_cu (
        .clk(clk), .rst_n(rst_n),
        .mask_data(cu_mask_data), .mask_valid(cu_mask_valid), .mask_ready(cu_mask_ready),
        .in_data(cu_in_data), .in_keep(cu_in_keep), .in_valid(cu_in_valid), .in_ready(cu_in_ready),
        .out_data(cu_out_data), .out_keep(cu_out_keep), .out_last(cu_out_last),
        .out_valid(cu_out_valid), .out_ready(cu_out_ready),
        .beat_count(cu_beat_count), .packet_count(cu_packet_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endfunction

    function automatic logic [W-1:0] stream_word(input int base, input int j);
        logic [W-1:0] r;
        for (int l = 0; l < N; l++) r[l*DW +: DW] = 32'(base + l * 256 + j);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mv, input logic [N:0] md, input logic [N-1:0] lv,
                         input logic [W-1:0] ld, input logic [N-1:0] lk);
        mask_valid = mv; mask_data = md; in_valid = lv; in_data = ld; in_keep = lk;
    endtask

    task automatic cu_drive(input logic mv, input logic [N:0] md, input logic [N-1:0] lv,
                            input logic [W-1:0] ld, input logic [N-1:0] lk);
        cu_mask_valid = mv; cu_mask_data = md; cu_in_valid = lv; cu_in_data = ld; cu_in_keep = lk;
    endtask

    task automatic expect_beat(input logic [W-1:0] d, input logic [N-1:0] k, input logic l);
        beat_t e;
        e.data = d; e.keep = k; e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic cu_expect_beat(input logic [W-1:0] d, input logic [N-1:0] k, input logic l);
        beat_t e;
        e.data = d; e.keep = k; e.last = l;
        cu_exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            $display("dut beat: data=%h keep=%b last=%b", out_data, out_keep, out_last);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got data=%h, required no beat", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat_data", out_data, mon_e.data);
                check("beat_keep", W'(out_keep), W'(mon_e.keep));
                check("beat_last", W'(out_last), W'(mon_e.last));
            end
        end
    end

    always @(negedge clk) begin
        if (cu_out_valid && cu_out_ready) begin
            $display("cu beat: data=%h keep=%b last=%b", cu_out_data, cu_out_keep, cu_out_last);
            if (cu_exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL cu_unexpected_beat: got data=%h, required no beat", cu_out_data);
            end else begin
                cu_mon_e = cu_exp_q.pop_front();
                check("cu_beat_data", cu_out_data, cu_mon_e.data);
                check("cu_beat_keep", W'(cu_out_keep), W'(cu_mon_e.keep));
                check("cu_beat_last", W'(cu_out_last), W'(cu_mon_e.last));
            end
        end
    end

    initial begin
        int m_cnt;
        int l_cnt;
        logic m_acc;
        logic l_acc;

        rst_n = 1'b1;
        out_ready = 1'b0;
        cu_out_ready = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        cu_drive(1'b0, '0, '0, '0, '0);
        #1 rst_n = 1'b0;
        #10;
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_data", out_data, W'(0));
        check("rst_out_keep", W'(out_keep), W'(0));
        check("rst_out_last", W'(out_last), W'(0));
        check("rst_beat_count", W'(beat_count), W'(0));
        check("rst_packet_count", W'(packet_count), W'(0));
        check("rst_mask_ready", W'(mask_ready), W'(0));
        check("rst_in_ready", W'(in_ready), W'(0));
        #11 rst_n = 1'b1;
        step();
        check("post_rst_mask_ready", W'(mask_ready), W'(1));
        check("post_rst_in_ready", W'(in_ready), W'(4'hF));

        // Full join, latency and first packet.
        out_ready = 1'b1;
        expect_beat(128'h000000A3_000000A2_000000A1_000000A0, 4'hF, 1'b1);
        drive(1'b1, {4'hF, 1'b1}, 4'hF, 128'h000000A3_000000A2_000000A1_000000A0, 4'hF);
        step();
        drive(1'b0, '0, '0, '0, '0);
        check("lat_edge_k", W'(out_valid), W'(0));
        step();
        check("lat_edge_k1", W'(out_valid), W'(1));
        step();
        check("lat_drained", W'(out_valid), W'(0));
        check("t1_packet_count", W'(packet_count), W'(1));
        check("t1_beat_count", W'(beat_count), W'(1));

        // Partial mask: unkept lanes are zeroed and left in their FIFOs.
        expect_beat(128'h00000000_000000C2_00000000_000000C0, 4'b0101, 1'b0);
        drive(1'b1, {4'b0101, 1'b0}, 4'hF, 128'h000000B3_000000C2_000000B1_000000C0, 4'b0111);
        step();
        drive(1'b0, '0, '0, '0, '0);
        repeat (3) step();
        check("held_no_output", W'(out_valid), W'(0));
        expect_beat(128'h000000B3_00000000_000000B1_00000000, 4'b0010, 1'b1);
        drive(1'b1, {4'b1010, 1'b1}, 4'h0, '0, '0);
        step();
        drive(1'b0, '0, '0, '0, '0);
        repeat (3) step();

        // Empty mask still forwards last.
        expect_beat('0, 4'b0000, 1'b1);
        drive(1'b1, {4'b0000, 1'b1}, 4'h0, '0, '0);
        step();
        drive(1'b0, '0, '0, '0, '0);
        repeat (3) step();
        check("t3_beat_count", W'(beat_count), W'(4));
        check("t3_packet_count", W'(packet_count), W'(3));

        // Backpressure: 20 stalled cycles, then release and drain.
        out_ready = 1'b0;
        m_cnt = 0;
        l_cnt = 0;
        for (int cyc = 0; cyc < 100 && (m_cnt < TOT || l_cnt < TOT); cyc++) begin
            if (cyc == 20) out_ready = 1'b1;
            drive(m_cnt < TOT, {4'hF, m_cnt[0]}, (l_cnt < TOT) ? 4'hF : 4'h0,
                  stream_word(32'h1000, l_cnt), 4'hF);
            @(negedge clk);
            m_acc = mask_valid && mask_ready;
            l_acc = in_valid[0] && in_ready[0];
            if (l_acc) expect_beat(stream_word(32'h1000, l_cnt), 4'hF, l_cnt[0]);
            @(posedge clk);
            #1;
            if (m_acc) m_cnt++;
            if (l_acc) l_cnt++;
            if (cyc == 19) begin
                check("stall_masks_taken", W'(m_cnt), W'(9));
                check("stall_lane_beats_taken", W'(l_cnt), W'(5));
                check("stall_mask_ready", W'(mask_ready), W'(0));
                check("stall_in_ready", W'(in_ready), W'(0));
                check("stall_out_valid", W'(out_valid), W'(1));
                check("stall_out_data", out_data, stream_word(32'h1000, 0));
                check("stall_out_last", W'(out_last), W'(0));
            end
        end
        drive(1'b0, '0, '0, '0, '0);
        repeat (8) step();
        check("t4_beat_count", W'(beat_count), W'(16));
        check("t4_packet_count", W'(packet_count), W'(9));

        // Back-to-back stream across the beat counter wrap.
        @(negedge clk);
        force dut.beat_count_q = 32'hFFFF_FFFE;
        step();
        release dut.beat_count_q;
        check("preset_beat_count", W'(beat_count), W'(32'hFFFF_FFFE));
        for (int i = 0; i < 4; i++) begin
            expect_beat(stream_word(32'h2000, i), 4'hF, i == 3);
            drive(1'b1, {4'hF, i == 3}, 4'hF, stream_word(32'h2000, i), 4'hF);
            step();
            check("stream_out_valid", W'(out_valid), W'(i != 0));
            if (i == 3) check("wrap_beat_count", W'(beat_count), W'(0));
        end
        drive(1'b0, '0, '0, '0, '0);
        step();
        check("stream_tail_valid", W'(out_valid), W'(1));
        step();
        check("stream_done_valid", W'(out_valid), W'(0));
        check("t5_beat_count", W'(beat_count), W'(2));
        check("t5_packet_count", W'(packet_count), W'(10));

        // CONSUME_UNKEPT=1: unkept lane 3 gates the join and every lane is popped.
        cu_out_ready = 1'b1;
        cu_drive(1'b1, {4'b0101, 1'b1}, 4'b0111, 128'h00000000_000000D2_000000D1_000000D0, 4'hF);
        step();
        cu_drive(1'b0, '0, '0, '0, '0);
        repeat (4) step();
        check("cu_waits_lane3", W'(cu_out_valid), W'(0));
        cu_expect_beat(128'h00000000_000000D2_00000000_000000D0, 4'b0101, 1'b1);
        cu_drive(1'b0, '0, 4'b1000, 128'h000000D3_00000000_00000000_00000000, 4'hF);
        step();
        cu_drive(1'b0, '0, '0, '0, '0);
        repeat (3) step();
        cu_expect_beat(128'h000000E3_000000E2_000000E1_000000E0, 4'hF, 1'b0);
        cu_drive(1'b1, {4'hF, 1'b0}, 4'hF, 128'h000000E3_000000E2_000000E1_000000E0, 4'hF);
        step();
        cu_drive(1'b0, '0, '0, '0, '0);
        repeat (3) step();
        check("cu_beat_count", W'(cu_beat_count), W'(2));
        check("cu_packet_count", W'(cu_packet_count), W'(1));

        // Asynchronous reset with buffered beats: nothing stale may come out.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, {4'hF, 1'b1}, 4'hF, stream_word(32'h3000, i), 4'hF);
            step();
        end
        drive(1'b0, '0, '0, '0, '0);
        check("prerst_out_valid", W'(out_valid), W'(1));
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", W'(out_valid), W'(0));
        check("async_rst_beat_count", W'(beat_count), W'(0));
        check("async_rst_packet_count", W'(packet_count), W'(0));
        check("async_rst_out_data", out_data, W'(0));
        check("async_rst_mask_ready", W'(mask_ready), W'(0));
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("rel_mask_ready", W'(mask_ready), W'(1));
        check("rel_in_ready", W'(in_ready), W'(4'hF));
        repeat (5) step();
        check("no_stale_out_valid", W'(out_valid), W'(0));
        check("no_stale_beat_count", W'(beat_count), W'(0));

        check("scoreboard_empty", W'(exp_q.size()), W'(0));
        check("cu_scoreboard_empty", W'(cu_exp_q.size()), W'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
